// File: rtl/nn_stream_pkg.sv
// Shared definitions for the network streaming blocks: default word width,
// the signed word type and the index-width helper.
package nn_stream_pkg;
   localparam int T_DEFAULT = 8;

   typedef logic signed [T_DEFAULT-1:0] word_t;

   // $clog2 that never returns 0, so a 1-entry index still has a bit.
   function automatic int clog2_min1(input int n);
      int r;
      r = $clog2(n);
      return (r < 1) ? 1 : r;
   endfunction
endpackage

// File: rtl/argmax_cmp.sv
// One step of the running argmax: fold a new word into the current best.
// Combinational; used for both mid-vector updates and the completing word.
module argmax_cmp
   import nn_stream_pkg::*;
#(
   parameter int T  = T_DEFAULT,
   parameter int IW = 2
) (
   input  logic signed [T-1:0]  best_val,
   input  logic        [IW-1:0] best_idx,
   input  logic signed [T-1:0]  data_in,
   input  logic        [IW-1:0] cnt,
   input  logic                 first,
   output logic signed [T-1:0]  next_val,
   output logic        [IW-1:0] next_idx
);
   always_comb begin
      next_val = best_val;
      next_idx = best_idx;
      if (first) begin
         next_val = data_in;
         next_idx = '0;
      end else if (data_in > best_val) begin
         // Strict compare: on ties the earlier (lower) index is kept.
         next_val = data_in;
         next_idx = cnt;
      end
   end
endmodule

// File: rtl/argmax_stream.sv
// Streams M signed words per vector and emits one (max value, index) result
// per vector through a single-entry output register.
module argmax_stream
   import nn_stream_pkg::*;
#(
   parameter int T  = T_DEFAULT,
   parameter int M  = 3,
   parameter int IW = clog2_min1(M)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 s_valid,
   input  logic                 m_ready,
   input  logic signed [T-1:0]  data_in,
   output logic                 m_valid,
   output logic                 s_ready,
   output logic signed [T-1:0]  data_out,
   output logic        [IW-1:0] index_out
);
   logic        [IW-1:0] cnt_q, cnt_d;
   logic signed [T-1:0]  best_val_q, best_val_d;
   logic        [IW-1:0] best_idx_q, best_idx_d;
   logic                 m_valid_q, m_valid_d;
   logic signed [T-1:0]  data_out_q, data_out_d;
   logic        [IW-1:0] index_out_q, index_out_d;

   logic                 last;
   logic                 s_fire;
   logic signed [T-1:0]  next_val;
   logic        [IW-1:0] next_idx;

   assign last    = (cnt_q == IW'(M-1));
   // Only the completing word needs a free output slot; earlier words always go.
   assign s_ready = !(last && m_valid_q && !m_ready);
   assign s_fire  = s_valid && s_ready;

   argmax_cmp #(.T(T), .IW(IW)) u_cmp (
      .best_val (best_val_q),
      .best_idx (best_idx_q),
      .data_in  (data_in),
      .cnt      (cnt_q),
      .first    (cnt_q == '0),
      .next_val (next_val),
      .next_idx (next_idx)
   );

   always_comb begin
      cnt_d       = cnt_q;
      best_val_d  = best_val_q;
      best_idx_d  = best_idx_q;
      m_valid_d   = m_valid_q;
      data_out_d  = data_out_q;
      index_out_d = index_out_q;

      if (m_valid_q && m_ready) m_valid_d = 1'b0;

      if (s_fire) begin
         best_val_d = next_val;
         best_idx_d = next_idx;
         if (last) begin
            cnt_d       = '0;
            data_out_d  = next_val;
            index_out_d = next_idx;
            m_valid_d   = 1'b1;
         end else begin
            cnt_d = cnt_q + IW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q       <= '0;
         best_val_q  <= '0;
         best_idx_q  <= '0;
         m_valid_q   <= 1'b0;
         data_out_q  <= '0;
         index_out_q <= '0;
      end else begin
         cnt_q       <= cnt_d;
         best_val_q  <= best_val_d;
         best_idx_q  <= best_idx_d;
         m_valid_q   <= m_valid_d;
         data_out_q  <= data_out_d;
         index_out_q <= index_out_d;
      end
   end

   assign m_valid   = m_valid_q;
   assign data_out  = data_out_q;
   assign index_out = index_out_q;
endmodule

// File: tb/tb_argmax_stream.sv
// Bench for argmax_stream: directed vectors plus randomized throttling on
// both handshakes, checked against a vector-level argmax model.
module tb_argmax_stream;
   localparam int T  = 8;
   localparam int M  = 3;
   localparam int IW = 2;
   localparam int NV = 400;

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic                 s_valid = 1'b0;
   logic                 m_ready = 1'b1;
   logic signed [T-1:0]  data_in = '0;
   logic                 m_valid;
   logic                 s_ready;
   logic signed [T-1:0]  data_out;
   logic        [IW-1:0] index_out;

   int checks   = 0;
   int failures = 0;
   int n_acc    = 0;
   int n_res    = 0;
   int n_push   = 0;

   typedef struct {int v; int i;} res_t;
   int   part[$];
   res_t expq[$];

   argmax_stream #(.T(T), .M(M)) dut (
      .clk       (clk),
      .reset     (reset),
      .s_valid   (s_valid),
      .m_ready   (m_ready),
      .data_in   (data_in),
      .m_valid   (m_valid),
      .s_ready   (s_ready),
      .data_out  (data_out),
      .index_out (index_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Argmax of a whole vector; first maximum wins.
   function automatic res_t vec_max(input int q[$]);
      res_t r;
      r.v = q[0];
      r.i = 0;
      foreach (q[k]) if (q[k] > r.v) begin r.v = q[k]; r.i = k; end
      return r;
   endfunction

   always @(negedge reset) begin
      part.delete();
      expq.delete();
   end

   // Monitor: inputs are stable here, so these flags are the next edge's handshakes.
   always @(negedge clk) begin
      res_t r;
      if (reset) begin
         chk("m_valid", int'(m_valid), int'(expq.size() != 0));
         chk("s_ready", int'(s_ready),
             int'(!(part.size() == M-1 && expq.size() != 0 && !m_ready)));
         if (m_valid && m_ready && expq.size() != 0) begin
            r = expq.pop_front();
            chk("res_val", int'(data_out), r.v);
            chk("res_idx", int'(index_out), r.i);
            n_res++;
         end
         if (s_valid && s_ready) begin
            part.push_back(int'(data_in));
            n_acc++;
            if (part.size() == M) begin
               expq.push_back(vec_max(part));
               part.delete();
            end
         end
      end
   end

   task automatic push(input int w);
      int k;
      s_valid = 1'b1;
      data_in = T'(w);
      k = 0;
      do begin @(negedge clk); k++; end while (!s_ready && k < 200);
      if (!s_ready) chk("push_timeout", 0, 1);
      @(posedge clk); #1;
      s_valid = 1'b0;
      n_push++;
   endtask

   task automatic vec(input int a, input int b, input int c, input int ev, input int ei);
      push(a); push(b); push(c);
      chk("lat_valid", int'(m_valid), 1);
      chk("vec_val", int'(data_out), ev);
      chk("vec_idx", int'(index_out), ei);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int cyc;
      #1;
      chk("rst_valid", int'(m_valid), 0);
      chk("rst_dout", int'(data_out), 0);
      chk("rst_idx", int'(index_out), 0);
      idle(2);
      reset = 1'b1;
      idle(1);

      vec(5, -3, 7, 7, 2);
      vec(-2, 9, 1, 9, 1);
      vec(4, 4, -1, 4, 0);
      vec(-128, -1, -2, -1, 1);
      vec(127, 127, 127, 127, 0);
      vec(-128, -128, -128, -128, 0);
      idle(2);

      // Backpressure: result held, next vector's first words still flow.
      m_ready = 1'b0;
      vec(1, 2, 3, 3, 2);
      push(6); push(5);
      s_valid = 1'b1;
      data_in = 8'sd4;
      repeat (5) begin
         @(negedge clk);
         chk("bp_sready", int'(s_ready), 0);
         chk("bp_hold_val", int'(data_out), 3);
         chk("bp_hold_idx", int'(index_out), 2);
      end
      @(posedge clk); #1;
      m_ready = 1'b1;
      @(negedge clk);
      chk("bp_release", int'(s_ready), 1);
      @(posedge clk); #1;
      s_valid = 1'b0;
      chk("bp_valid", int'(m_valid), 1);
      chk("bp_val", int'(data_out), 6);
      chk("bp_idx", int'(index_out), 0);
      idle(2);

      // Reset mid-vector.
      push(10); push(20);
      reset = 1'b0;
      #1;
      chk("mrst_valid", int'(m_valid), 0);
      chk("mrst_dout", int'(data_out), 0);
      chk("mrst_idx", int'(index_out), 0);
      @(posedge clk); #1;
      reset = 1'b1;
      idle(1);
      vec(1, 0, -5, 1, 0);
      idle(2);

      // Randomized throttle on both sides.
      n_acc = 0;
      n_res = 0;
      cyc = 0;
      while (n_acc < NV*M && cyc < 20000) begin
         s_valid = ($urandom_range(0, 3) != 0);
         m_ready = ($urandom_range(0, 2) != 0);
         case ($urandom_range(0, 4))
            0:       data_in = -8'sd128;
            1:       data_in = 8'sd127;
            2:       data_in = T'($urandom_range(0, 4)) - 8'sd2;
            default: data_in = T'($urandom);
         endcase
         @(posedge clk); #1;
         cyc++;
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      cyc = 0;
      while (expq.size() != 0 && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("rand_words", n_acc, NV*M);
      chk("rand_results", n_res, NV);
      chk("drain_empty", expq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/argmax_stream.md
Name: argmax_stream

Overview:
- Downstream consumer of the network_* streaming output.
- Takes the serial stream of signed T-bit output-layer values, M words per vector, and emits one result per vector: the index and value of the maximum element.
- Both sides use the codebase's valid/ready streaming handshake, so it chains directly after a network block or feeds a result sink.

Parameters:
- T, 8, data word width (signed two's complement)
- M, 3, words per vector (output-layer size of the upstream network); M >= 2
- IW, $clog2(M) (min 1), width of index_out

Ports:
- clk  input  1  clock, rising-edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- s_valid  input  1  upstream word valid
- m_ready  input  1  downstream ready for result
- data_in  input  T  signed upstream word
- m_valid  output  1  result valid
- s_ready  output  1  block can accept data_in this cycle
- data_out  output  T  signed max value of completed vector
- index_out  output  IW  position (0..M-1) of max within vector

Behaviour:
- Reset (reset==0, async assert, sync-released on clk): cnt=0, best_val=0, best_idx=0, m_valid=0, data_out=0, index_out=0. Reset mid-vector discards the partial vector and any unread result.
- Transfers occur only on a rising edge with valid&&ready on that side. Inputs do not change state without a handshake.
- Accumulator (cnt 0..M-1, best_val, best_idx):
  - Accepted word with cnt==0: best_val<=data_in, best_idx<=0.
  - Accepted word with cnt>0: update to (data_in, cnt) only if data_in > best_val, signed strict compare. Ties keep the lowest index.
  - cnt increments per accepted word and wraps M-1 -> 0.
- Completion: the word accepted at cnt==M-1 is folded combinationally into the final compare.
  - The result loads into the output register (data_out, index_out) on the same edge, and m_valid<=1.
  - Latency: m_valid high the cycle after the last word's handshake.
- Output register:
  - Holds stable while m_valid && !m_ready.
  - m_valid clears on handshake unless a new result loads on the same edge; in that case it stays 1 with new data.
- s_ready = !(cnt==M-1 && m_valid && !m_ready).
  - Words 0..M-2 of the next vector are always accepted, even under backpressure.
  - Only the completing word stalls.
  - Full throughput is one vector per M cycles with no bubbles.
- s_ready is combinational from m_ready. There is no combinational path from s_valid to m_valid.
- data_out and index_out are don't-care semantically when m_valid=0, but retain their last value.
- Arithmetic: no widening. The compare is a signed T-bit compare. -2^(T-1) is legal.

Decomposition:
- Shared package nn_stream_pkg:
  - default T
  - typedef logic signed [T-1:0] word_t
  - helper function clog2_min1 for IW
- One natural sub-module, argmax_cmp (combinational):
  - in: best_val, best_idx, data_in, cnt, first
  - out: next_val, next_idx
  - Reused for the in-flight and final compare.
- Counter, output register and handshake logic stay in argmax_stream.

Test Plan:
- Basic: after reset, send vectors (5,-3,7) and (-2,9,1), m_ready=1 → results (val 7, idx 2), then (val 9, idx 1). m_valid rises 1 cycle after each third word.
- Ties and extremes: (4,4,-1) → (4,0). (-128,-1,-2) → (-1,1). (127,127,127) → (127,0). (-128,-128,-128) → (-128,0).
- Backpressure: m_ready=0 for 12 cycles, s_valid=1 with vectors (1,2,3),(6,5,4).
  - First result (3,2) is held stable.
  - (6,5) are accepted; s_ready=0 while 4 is presented.
  - When m_ready rises: (3,2) is consumed, 4 is accepted the same edge, then (6,0) follows.
- Reset mid-operation:
  - Accept 2 words (10,20), pulse reset low for 1 cycle → m_valid=0, outputs 0.
  - Next (1,0,-5) → (1,0); the stale 10/20 have no effect.
- Randomized throttle, mirroring the network bench: rb/rb2 random s_valid/m_ready, 10000 random vectors from a .in file (readmemb) → all 10000 results match the .exp file. Error count 0, no lost or duplicated results.
